// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS constants and framer state encoding.
// Used by both the transmit framer and the receive-side sync recovery.
package ts_pkg;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int          TS_PKT_LEN   = 188;
  localparam int          TS_HDR_LEN   = 4;
  localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA_HDR,
    ST_DATA_PAY,
    ST_NULL_HDR,
    ST_NULL_PAY
  } ts_state_e;

endpackage

// File: rtl/ts_header_gen.sv
// Combinational TS header byte generator.
// Null packets force PUSI and the CC nibble to zero.
import ts_pkg::*;

module ts_header_gen (
  input  logic [12:0] i_pid,
  input  logic        i_pusi,
  input  logic [3:0]  i_cc,
  input  logic        i_null,
  input  logic [1:0]  i_idx,
  output logic [7:0]  o_byte
);

  logic       w_pusi;
  logic [3:0] w_cc;

  assign w_pusi = i_pusi & ~i_null;
  assign w_cc   = i_null ? 4'h0 : i_cc;

  always_comb begin
    o_byte = TS_SYNC_BYTE;
    unique case (i_idx)
      2'd0: o_byte = TS_SYNC_BYTE;
      2'd1: o_byte = {1'b0, w_pusi, 1'b0, i_pid[12:8]};
      2'd2: o_byte = i_pid[7:0];
      2'd3: o_byte = {2'b00, 2'b01, w_cc};
      default: o_byte = TS_SYNC_BYTE;
    endcase
  end

endmodule

// File: rtl/ts_packet_framer.sv
// Transmit-side MPEG-2 TS framer: packs payload bytes into 188-byte
// packets, optionally filling idle time with null packets.
import ts_pkg::*;

module ts_packet_framer #(
  parameter logic [12:0] NULL_PID    = TS_NULL_PID,
  parameter int          PAYLOAD_LEN = 184
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] cfg_pid,
  input  logic        null_en,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        pkt_start,
  output logic        pkt_null,
  output logic [15:0] pkt_count
);

  localparam logic [7:0] HDR_LAST = 8'(TS_HDR_LEN - 1);
  localparam logic [7:0] LAST_IDX = 8'(TS_HDR_LEN + PAYLOAD_LEN - 1);

  ts_state_e   r_state;
  logic [7:0]  r_idx;
  logic [3:0]  r_cc;
  logic [12:0] r_pid;
  logic        r_pusi;
  logic [7:0]  r_byte;
  logic        r_valid;
  logic        r_start;
  logic        r_null;
  logic [15:0] r_count;

  ts_state_e   w_state_nx;
  logic [7:0]  w_idx_nx;
  logic [3:0]  w_cc_nx;
  logic [12:0] w_pid_nx;
  logic        w_pusi_nx;
  logic [7:0]  w_byte_nx;
  logic        w_valid_nx;
  logic        w_start_nx;
  logic        w_null_nx;
  logic [15:0] w_count_nx;

  logic        w_in_null;
  logic [12:0] w_hdr_pid;
  logic [7:0]  w_hdr_byte;

  assign w_in_null = (r_state == ST_NULL_HDR);
  assign w_hdr_pid = w_in_null ? NULL_PID : r_pid;

  ts_header_gen u_hdr (
    .i_pid  (w_hdr_pid),
    .i_pusi (r_pusi),
    .i_cc   (r_cc),
    .i_null (w_in_null),
    .i_idx  (r_idx[1:0]),
    .o_byte (w_hdr_byte)
  );

  assign in_ready = (r_state == ST_DATA_PAY);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cc_nx    = r_cc;
    w_pid_nx   = r_pid;
    w_pusi_nx  = r_pusi;
    w_byte_nx  = r_byte;
    w_valid_nx = 1'b0;
    w_start_nx = 1'b0;
    w_null_nx  = 1'b0;
    w_count_nx = r_count;
    unique case (r_state)
      ST_IDLE: begin
        w_idx_nx = 8'd0;
        if (in_valid) begin
          w_state_nx = ST_DATA_HDR;
          w_pid_nx   = cfg_pid;
          w_pusi_nx  = in_sop;
          w_byte_nx  = TS_SYNC_BYTE;
          w_valid_nx = 1'b1;
          w_start_nx = 1'b1;
          w_idx_nx   = 8'd1;
        end else if (null_en) begin
          w_state_nx = ST_NULL_HDR;
          w_byte_nx  = TS_SYNC_BYTE;
          w_valid_nx = 1'b1;
          w_start_nx = 1'b1;
          w_null_nx  = 1'b1;
          w_idx_nx   = 8'd1;
        end
      end
      ST_DATA_HDR, ST_NULL_HDR: begin
        w_byte_nx  = w_hdr_byte;
        w_valid_nx = 1'b1;
        w_idx_nx   = r_idx + 8'd1;
        if (r_idx == HDR_LAST)
          w_state_nx = w_in_null ? ST_NULL_PAY : ST_DATA_PAY;
      end
      ST_DATA_PAY: begin
        // Underrun simply holds idx; the packet resumes when data returns.
        if (in_valid) begin
          w_byte_nx  = in_data;
          w_valid_nx = 1'b1;
          w_idx_nx   = r_idx + 8'd1;
          if (r_idx == LAST_IDX) begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = 8'd0;
            w_cc_nx    = r_cc + 4'd1;
            w_count_nx = r_count + 16'd1;
          end
        end
      end
      ST_NULL_PAY: begin
        w_byte_nx  = 8'hFF;
        w_valid_nx = 1'b1;
        w_idx_nx   = r_idx + 8'd1;
        if (r_idx == LAST_IDX) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = 8'd0;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_idx_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 8'd0;
      r_cc    <= 4'd0;
      r_pid   <= 13'd0;
      r_pusi  <= 1'b0;
      r_byte  <= 8'd0;
      r_valid <= 1'b0;
      r_start <= 1'b0;
      r_null  <= 1'b0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_cc    <= w_cc_nx;
      r_pid   <= w_pid_nx;
      r_pusi  <= w_pusi_nx;
      r_byte  <= w_byte_nx;
      r_valid <= w_valid_nx;
      r_start <= w_start_nx;
      r_null  <= w_null_nx;
      r_count <= w_count_nx;
    end
  end

  assign byte_out   = r_byte;
  assign byte_valid = r_valid;
  assign pkt_start  = r_start;
  assign pkt_null   = r_null;
  assign pkt_count  = r_count;

endmodule
